// File: rtl/lane_step_sched.sv
// lane_step_sched: per-lane step scheduler for the road section.
//
// Divides the system clock into a base tick (c_BASE_DIV cycles) and, per lane, divides the
// base tick by an effective period that shrinks with the active game level. Each lane emits a
// one-cycle strobe when its period elapses. A small IDLE/RUN/PAUSED FSM gates the prescaler.
//
// Optional feature macro: LANE_SCHED_STAGGER_EN
//   When defined, reset/stop preload lane counter i with (i mod eff_i) to de-phase lanes.
//
// Ports:
//   i_Clk         system clock
//   i_Rst         synchronous active-high reset
//   i_Start       level request to leave IDLE
//   i_Pause       level freeze request
//   i_Stop        one-cycle request to return to IDLE
//   i_Level       requested level
//   i_Level_Load  strobe capturing i_Level into the pending register
//   o_Level_Ack   pulse when the pending level becomes active
//   o_Lane_Step   per-lane step strobes
//   o_Base_Tick   pulse per base tick
//   o_State       0=IDLE, 1=RUN, 2=PAUSED
module lane_step_sched #(
    parameter int unsigned NUM_LANES = 5,
    parameter int unsigned c_BASE_DIV = 340000,
    parameter int unsigned DIV_WIDTH = 19,
    parameter logic [4*NUM_LANES-1:0] c_LANE_PERIOD = {4'd3, 4'd2, 4'd4, 4'd3, 4'd2}
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_Start,
    input  logic                 i_Pause,
    input  logic                 i_Stop,
    input  logic [2:0]           i_Level,
    input  logic                 i_Level_Load,
    output logic                 o_Level_Ack,
    output logic [NUM_LANES-1:0] o_Lane_Step,
    output logic                 o_Base_Tick,
    output logic [1:0]           o_State
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StPaused = 2'd2
    } state_e;

    localparam logic [DIV_WIDTH-1:0] DivLast = DIV_WIDTH'(c_BASE_DIV - 1);

    state_e                      state_q, state_d;
    logic [DIV_WIDTH-1:0]        presc_q, presc_d;
    logic [NUM_LANES-1:0][3:0]   cnt_q, cnt_d;
    logic [2:0]                  level_q, level_d;
    logic [2:0]                  pend_lvl_q, pend_lvl_d;
    logic                        pend_q, pend_d;
    logic                        ack_q, ack_d;
    logic                        tick_q, tick_d;
    logic [NUM_LANES-1:0]        step_q, step_d;

    logic       tick;
    logic       pend_any;
    logic [2:0] pend_val;
    logic       apply;

    // Effective period of a lane at a given level, never below 1.
    function automatic logic [3:0] eff_period(input int lane, input logic [2:0] lvl);
        logic [3:0] p;
        p = c_LANE_PERIOD[lane*4 +: 4];
        if (p == 4'd0) p = 4'd1;
        if (p > {1'b0, lvl}) return p - {1'b0, lvl};
        return 4'd1;
    endfunction

`ifdef LANE_SCHED_STAGGER_EN
    function automatic logic [NUM_LANES-1:0][3:0] lane_init(input logic [2:0] lvl);
        logic [NUM_LANES-1:0][3:0] v;
        for (int i = 0; i < NUM_LANES; i++) begin
            v[i] = 4'(i % int'(eff_period(i, lvl)));
        end
        return v;
    endfunction
`endif

    assign tick     = (state_q == StRun) && (presc_q == DivLast);
    // A load in the same cycle is treated as already pending.
    assign pend_any = i_Level_Load | pend_q;
    assign pend_val = i_Level_Load ? i_Level : pend_lvl_q;
    // In RUN the level only switches right after a tick so that tick still sees the old level.
    assign apply    = !i_Stop && pend_any && ((state_q != StRun) || tick);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!i_Stop && !i_Pause && i_Start) state_d = StRun;
            end
            StRun: begin
                if (i_Stop) state_d = StIdle;
                else if (i_Pause) state_d = StPaused;
            end
            StPaused: begin
                if (i_Stop) state_d = StIdle;
                else if (!i_Pause) state_d = StRun;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        presc_d    = presc_q;
        cnt_d      = cnt_q;
        step_d     = '0;
        tick_d     = 1'b0;
        level_d    = level_q;
        pend_lvl_d = i_Level_Load ? i_Level : pend_lvl_q;
        pend_d     = pend_any;
        ack_d      = 1'b0;

        if (i_Stop) begin
            presc_d = '0;
            pend_d  = 1'b0;
`ifdef LANE_SCHED_STAGGER_EN
            cnt_d   = lane_init(level_q);
`else
            cnt_d   = '0;
`endif
        end else begin
            if (state_q == StRun) begin
                presc_d = tick ? '0 : presc_q + DIV_WIDTH'(1);
            end
            if (tick) begin
                tick_d = 1'b1;
                for (int i = 0; i < NUM_LANES; i++) begin
                    // >= so a counter above a freshly shortened period fires at once.
                    if (cnt_q[i] >= eff_period(i, level_q) - 4'd1) begin
                        cnt_d[i]  = 4'd0;
                        step_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 4'd1;
                    end
                end
            end
            if (apply) begin
                level_d = pend_val;
                pend_d  = 1'b0;
                ack_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q    <= StIdle;
            presc_q    <= '0;
`ifdef LANE_SCHED_STAGGER_EN
            cnt_q      <= lane_init(3'd0);
`else
            cnt_q      <= '0;
`endif
            level_q    <= 3'd0;
            pend_lvl_q <= 3'd0;
            pend_q     <= 1'b0;
            ack_q      <= 1'b0;
            tick_q     <= 1'b0;
            step_q     <= '0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            pend_lvl_q <= pend_lvl_d;
            pend_q     <= pend_d;
            ack_q      <= ack_d;
            tick_q     <= tick_d;
            step_q     <= step_d;
        end
    end

    assign o_State     = state_q;
    assign o_Level_Ack = ack_q;
    assign o_Base_Tick = tick_q;
    assign o_Lane_Step = step_q;

endmodule

// File: tb/tb_lane_step_sched.sv
module tb_lane_step_sched;

    localparam int NL  = 5;
    localparam int DIV = 4;
    localparam int DW  = 3;
    // lane4..lane0 = 2,4,1,3,2 -> lane0..4 = {2,3,1,4,2}
    localparam logic [4*NL-1:0] PER = {4'd2, 4'd4, 4'd1, 4'd3, 4'd2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, pause, stop, lload;
    logic [2:0]    lvl;
    logic          ack, btick;
    logic [NL-1:0] steps;
    logic [1:0]    state;

    lane_step_sched #(
        .NUM_LANES    (NL),
        .c_BASE_DIV   (DIV),
        .DIV_WIDTH    (DW),
        .c_LANE_PERIOD(PER)
    ) dut (
        .i_Clk       (clk),
        .i_Rst       (rst),
        .i_Start     (start),
        .i_Pause     (pause),
        .i_Stop      (stop),
        .i_Level     (lvl),
        .i_Level_Load(lload),
        .o_Level_Ack (ack),
        .o_Lane_Step (steps),
        .o_Base_Tick (btick),
        .o_State     (state)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: lane periods stated directly, everything in plain integers.
    int per[NL] = '{2, 3, 1, 4, 2};
    int m_state, m_presc, m_level, m_pend, m_pend_lvl;
    int m_cnt[NL];
    logic          e_tick, e_ack;
    logic [NL-1:0] e_step;
    logic [1:0]    e_state;

    function automatic int eff(int i, int l);
        int p;
        p = (per[i] == 0) ? 1 : per[i];
        return (p > l) ? p - l : 1;
    endfunction

    function automatic int init_cnt(int i, int l);
`ifdef LANE_SCHED_STAGGER_EN
        return i % eff(i, l);
`else
        return 0;
`endif
    endfunction

    task automatic model_step();
        bit running, tk;
        if (rst) begin
            m_state = 0; m_presc = 0; m_level = 0; m_pend = 0; m_pend_lvl = 0;
            for (int i = 0; i < NL; i++) m_cnt[i] = init_cnt(i, 0);
            e_tick = 0; e_step = '0; e_ack = 0;
        end else begin
            running = (m_state == 1);
            tk = running && (m_presc == DIV - 1);
            e_tick = 0; e_step = '0; e_ack = 0;
            if (lload) begin
                m_pend = 1;
                m_pend_lvl = int'(lvl);
            end
            if (stop) begin
                m_presc = 0;
                m_pend = 0;
                for (int i = 0; i < NL; i++) m_cnt[i] = init_cnt(i, m_level);
            end else begin
                if (running) m_presc = (m_presc + 1) % DIV;
                if (tk) begin
                    e_tick = 1;
                    for (int i = 0; i < NL; i++) begin
                        if (m_cnt[i] + 1 >= eff(i, m_level)) begin
                            m_cnt[i] = 0;
                            e_step[i] = 1'b1;
                        end else begin
                            m_cnt[i]++;
                        end
                    end
                end
                if (m_pend != 0 && (!running || tk)) begin
                    m_level = m_pend_lvl;
                    m_pend = 0;
                    e_ack = 1;
                end
            end
            if (stop) m_state = 0;
            else if (m_state == 0) m_state = (!pause && start) ? 1 : 0;
            else if (pause) m_state = 2;
            else m_state = 1;
        end
        e_state = 2'(m_state);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        check("state", 32'(state), 32'(e_state));
        check("base_tick", 32'(btick), 32'(e_tick));
        check("lane_step", 32'(steps), 32'(e_step));
        check("level_ack", 32'(ack), 32'(e_ack));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    initial begin
        rst = 1; start = 0; pause = 0; stop = 0; lload = 0; lvl = 0;
        m_state = 0; m_presc = 0; m_level = 0; m_pend = 0; m_pend_lvl = 0;
        for (int i = 0; i < NL; i++) m_cnt[i] = 0;
        @(negedge clk);
        step();
        check("reset_state", 32'(state), 32'd0);
        check("reset_steps", 32'(steps), 32'd0);
        check("reset_tick", 32'(btick), 32'd0);
        check("reset_ack", 32'(ack), 32'd0);

        // Scenario 1: free run from cycle 0.
        rst = 0; start = 1;
        step();
        for (int c = 1; c <= 16; c++) begin
            step();
            if (c == 4) check("s1_tick4", 32'(btick), 32'd1);
            if (c == 5) check("s1_tick5", 32'(btick), 32'd0);
`ifndef LANE_SCHED_STAGGER_EN
            if (c == 4) check("s1_step4", 32'(steps), 32'b00100);
            if (c == 8) check("s1_step8", 32'(steps), 32'b10101);
            if (c == 12) check("s1_step12", 32'(steps), 32'b00110);
            if (c == 16) check("s1_step16", 32'(steps), 32'b11101);
`else
            if (c == 4) check("stag_lane3", 32'(steps[3]), 32'd1);
            if (c == 8) check("stag_lane1", 32'(steps[1]), 32'd1);
`endif
        end

        // Stop and pause together: stop wins.
        stop = 1; pause = 1;
        step();
        check("stop_state", 32'(state), 32'd0);
        stop = 0; pause = 0; start = 0;

        // Level 5 in IDLE: ack next cycle, then all lanes eff=1.
        lload = 1; lvl = 3'd5;
        step();
        check("idle_ack", 32'(ack), 32'd1);
        lload = 0; start = 1;
        step();
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 4) check("lvl5_all", 32'(steps), 32'b11111);
        end

        // Back to level 0, then load level 1 at cycle 5 of a fresh run.
        stop = 1; start = 0;
        step();
        stop = 0; lload = 1; lvl = 3'd0;
        step();
        lload = 0; start = 1;
        step();
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c == 7) check("run_ack7", 32'(ack), 32'd0);
            if (c == 8) check("run_ack8", 32'(ack), 32'd1);
`ifndef LANE_SCHED_STAGGER_EN
            if (c == 8) check("run_step8", 32'(steps), 32'b10101);
            if (c == 12) check("run_step12", 32'(steps), 32'b11111);
`endif
            lload = (c == 5);
            lvl = 3'd1;
        end
        lload = 0;

        // Reset mid-run.
        rst = 1;
        step();
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_steps", 32'(steps), 32'd0);
        rst = 0;

        // Randomised phase.
        for (int n = 0; n < 4000; n++) begin
            rst   = ($urandom_range(0, 299) == 0);
            stop  = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 19) == 0) pause = ~pause;
            start = ($urandom_range(0, 9) < 7);
            lload = ($urandom_range(0, 14) == 0);
            lvl   = 3'($urandom_range(0, 7));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lane_step_sched.md
# lane_step_sched

Per-lane step scheduler for the road section of the game. It turns the system clock into one-cycle step strobes, one per traffic lane. Each lane has its own period, which shortens as the game level rises. The car position logic moves a lane's cars only when that lane's strobe fires. The block sits between the game-state FSM (start/pause/stop/level) and the car-position datapath, and replaces free-running per-module slowdown counters.

## Interface
Parameters:
- NUM_LANES, 5, number of lanes scheduled.
- c_BASE_DIV, 340000, system-clock cycles per base tick; legal range ≥ 2.
- DIV_WIDTH, 19, prescaler width; must satisfy 2^DIV_WIDTH ≥ c_BASE_DIV.
- c_LANE_PERIOD, {4'd3, 4'd2, 4'd4, 4'd3, 4'd2}, packed 4-bit base-tick period per lane; lane i is bits [i*4 +: 4]. A value of 0 is treated as 1.

Ports:
- i_Clk, in, 1, system clock.
- i_Rst, in, 1, synchronous active-high reset.
- i_Start, in, 1, level-sensitive request to leave IDLE.
- i_Pause, in, 1, level-sensitive freeze while high.
- i_Stop, in, 1, one-cycle request to return to IDLE.
- i_Level, in, 3, requested level value.
- i_Level_Load, in, 1, one-cycle strobe that captures i_Level.
- o_Level_Ack, out, 1, one-cycle pulse when the captured level takes effect.
- o_Lane_Step, out, NUM_LANES, one-cycle step strobes.
- o_Base_Tick, out, 1, one-cycle pulse per base tick.
- o_State, out, 2, current state: 0=IDLE, 1=RUN, 2=PAUSED.

## Operation
- States:
  - IDLE → RUN when i_Start is high.
  - RUN → PAUSED when i_Pause is high.
  - PAUSED → RUN when i_Pause is low.
  - RUN or PAUSED → IDLE when i_Stop is high.
- Priority: i_Rst > i_Stop > i_Pause > i_Start.
- Prescaler:
  - Counts 0..c_BASE_DIV-1 in RUN only.
  - The internal base tick is the RUN cycle where the prescaler equals c_BASE_DIV-1; the prescaler then wraps to 0.
- Effective period: eff_i = (P_i > L) ? P_i − L : 1, where P_i is the lane period (0 treated as 1) and L is the active level. Compute in 4 bits with no underflow.
- Lane counter update, on each base tick:
  - If cnt_i ≥ eff_i − 1: cnt_i ← 0 and strobe lane i.
  - Otherwise: cnt_i ← cnt_i + 1.
  - The ≥ comparison means a counter above a newly shortened period steps on the next tick, never stalls.
- Several lanes may strobe in the same cycle; there is no arbitration between lanes.
- Level handshake:
  - i_Level_Load captures i_Level into a pending register and sets a pending flag.
  - In IDLE or PAUSED, the pending level is applied on the next cycle.
  - In RUN, the pending level is applied on the cycle after the next base tick, so lane updates at that tick still use the old level.
  - o_Level_Ack pulses in the cycle the level is applied.
  - A second load before the apply overwrites the pending value and produces one ack only.
- i_Stop: clears the prescaler, lane counters and pending flag. The active level is kept.
- PAUSED freezes the prescaler and lane counters and emits no strobes. Resuming continues from the frozen values.

## Timing
- Reset values: o_Lane_Step=0, o_Base_Tick=0, o_Level_Ack=0, o_State=0 (IDLE). Prescaler, lane counters, active level and pending flag are all 0.
- Reset mid-operation has the same effect, including strobes already in flight.
- All outputs are registered.
- o_Base_Tick and o_Lane_Step assert one cycle after the internal tick cycle.
- o_State reflects a transition one cycle after the request is sampled.
- Entering PAUSED on the cycle of an internal tick: that tick is still processed and its strobes still emitted.
- Stop on the cycle of an internal tick: the tick is discarded and no strobes are emitted.

## Configuration
- LANE_SCHED_STAGGER_EN defined:
  - On reset or stop, cnt_i is preloaded with i mod eff_i, so lanes sharing a period do not step in lockstep.
- Not defined:
  - All counters clear to 0.
  - First strobe of lane i comes at base tick eff_i.

## Test plan
Parameters for all scenarios: c_BASE_DIV=4, periods lane0..4 = {2,3,1,4,2}, macro off.
- Reset, then hold i_Start. RUN begins at cycle 0 → o_Base_Tick at cycles 4, 8, 12. o_Lane_Step[2] with each tick. o_Lane_Step[0] at 8, 16. o_Lane_Step[1] at 12, 24. o_Lane_Step[3] at 16.
- In IDLE, load level 5 → o_Level_Ack the next cycle. In RUN every lane has eff=1 and all five strobes fire together at cycle 4.
- In RUN, load level 1 at cycle 5 → ack at cycle 8. Lane3 eff becomes 3. The tick at cycle 7 used level 0; lane3 strobes at cycle 12 (cnt=2 ≥ 2).
- Pause for 10 cycles after cycle 5 → no strobes while paused. After release, the remaining prescaler count of 2 plus one cycle gives the next o_Base_Tick 3 cycles later.
- Assert i_Stop and i_Pause together in RUN → o_State=IDLE, counters 0, and no strobe for a tick coinciding with the stop. Assert i_Rst mid-RUN → all outputs 0 the next cycle.
- Define LANE_SCHED_STAGGER_EN and repeat scenario 1 → lane1 (cnt preload 1) first strobes at cycle 8. Lane3 (preload 3, eff 4) strobes at cycle 4.
